// File: rtl/vdp_pkg.sv
// ============================================================================
// Module : vdp_pkg
// Brief  : Shared sprite-pipeline types for the matcher, line list and fetcher.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vdp_pkg;

   localparam int MAX_SPRITES_PER_LINE = 16;

   localparam int SPR_IDX_W  = 9;
   localparam int SPR_ROW_W  = 6;
   localparam int SPR_X_W    = 12;
   localparam int SPR_WID_W  = 6;
   localparam int SPR_ADDR_W = 16;

   typedef struct packed {
      logic [SPR_IDX_W-1:0]  index;
      logic [SPR_ROW_W-1:0]  row;
      logic [SPR_X_W-1:0]    x;
      logic [SPR_WID_W-1:0]  width;
      logic [SPR_ADDR_W-1:0] addr;
   } sprite_entry_t;

   typedef enum logic [0:0] {
      LIST_IDLE   = 1'b0,
      LIST_STREAM = 1'b1
   } list_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_list_bank.sv
// ============================================================================
// Module : sprite_list_bank
// Brief  : DEPTH-entry register file, one write port, combinational read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_list_bank #(
   parameter int DEPTH     = 16,
   parameter int ENTRY_W   = 49,
   parameter int ADDR_BITS = $clog2(DEPTH)
) (
   input  logic                 clk_draw,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [ENTRY_W-1:0]   wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [ENTRY_W-1:0]   rdata
);

   // Contents are don't-care after reset, so the array carries no reset.
   logic [ENTRY_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk_draw) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sprite_line_list.sv
// ============================================================================
// Module : sprite_line_list
// Brief  : Double-buffered per-line sprite list; fills one bank, streams other.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_line_list
   import vdp_pkg::*;
#(
   parameter int MAX_SPRITES = MAX_SPRITES_PER_LINE,
   parameter int IDX_W       = SPR_IDX_W,
   parameter int ROW_W       = SPR_ROW_W,
   parameter int X_W         = SPR_X_W,
   parameter int WID_W       = SPR_WID_W,
   parameter int ADDR_W      = SPR_ADDR_W
) (
   input  logic                         clk_draw,
   input  logic                         rst_draw,
   input  logic                         line,
   input  logic                         match_valid,
   input  logic [IDX_W-1:0]             match_index,
   input  logic [ROW_W-1:0]             match_row,
   input  logic [X_W-1:0]               match_x,
   input  logic [WID_W-1:0]             match_width,
   input  logic [ADDR_W-1:0]            match_addr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [IDX_W-1:0]             out_index,
   output logic [ROW_W-1:0]             out_row,
   output logic [X_W-1:0]               out_x,
   output logic [WID_W-1:0]             out_width,
   output logic [ADDR_W-1:0]            out_addr,
   output logic                         out_last,
   output logic [$clog2(MAX_SPRITES):0] out_count,
   output logic                         overflow
);

   localparam int c_PTR_W   = $clog2(MAX_SPRITES);
   localparam int c_CNT_W   = c_PTR_W + 1;
   localparam int c_ENTRY_W = $bits(sprite_entry_t);

   logic               r_wbank;
   logic [c_CNT_W-1:0] r_wcount;
   logic               r_wovf;
   logic [c_CNT_W-1:0] r_rcount;
   logic               r_overflow;
   logic [c_PTR_W-1:0] r_rptr;
   list_state_t        r_state;

   logic               w_accept;
   logic               w_drop;
   logic [c_CNT_W-1:0] w_swap_count;
   logic               w_handshake;
   sprite_entry_t      w_wr_entry;
   sprite_entry_t      w_rd_entry;
   logic [c_ENTRY_W-1:0] w_rdata [2];

   assign w_accept     = match_valid && (r_wcount < c_CNT_W'(MAX_SPRITES));
   assign w_drop       = match_valid && !w_accept;
   // Counts include a match coincident with line: it belongs to the retiring bank.
   assign w_swap_count = r_wcount + c_CNT_W'(w_accept);

   always_comb begin
      w_wr_entry       = '0;
      w_wr_entry.index = match_index;
      w_wr_entry.row   = match_row;
      w_wr_entry.x     = match_x;
      w_wr_entry.width = match_width;
      w_wr_entry.addr  = match_addr;
   end

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         sprite_list_bank #(
            .DEPTH   (MAX_SPRITES),
            .ENTRY_W (c_ENTRY_W)
         ) u_bank (
            .clk_draw (clk_draw),
            .we       (w_accept && (r_wbank == 1'(b))),
            .waddr    (r_wcount[c_PTR_W-1:0]),
            .wdata    (w_wr_entry),
            .raddr    (r_rptr),
            .rdata    (w_rdata[b])
         );
      end
   endgenerate

   assign w_rd_entry  = sprite_entry_t'(w_rdata[~r_wbank]);

   assign out_valid   = (r_state == LIST_STREAM);
   assign out_last    = out_valid && ({1'b0, r_rptr} == (r_rcount - c_CNT_W'(1)));
   assign out_index   = w_rd_entry.index;
   assign out_row     = w_rd_entry.row;
   assign out_x       = w_rd_entry.x;
   assign out_width   = w_rd_entry.width;
   assign out_addr    = w_rd_entry.addr;
   assign out_count   = r_rcount;
   assign overflow    = r_overflow;
   assign w_handshake = out_valid && out_ready;

   always_ff @(posedge clk_draw) begin
      if (rst_draw) begin
         r_wbank    <= 1'b0;
         r_wcount   <= '0;
         r_wovf     <= 1'b0;
         r_rcount   <= '0;
         r_overflow <= 1'b0;
         r_rptr     <= '0;
         r_state    <= LIST_IDLE;
      end else if (line) begin
         // A handshake this cycle completed against the old bank; nothing to track.
         r_wbank    <= ~r_wbank;
         r_rcount   <= w_swap_count;
         r_overflow <= r_wovf | w_drop;
         r_wcount   <= '0;
         r_wovf     <= 1'b0;
         r_rptr     <= '0;
         r_state    <= (w_swap_count != '0) ? LIST_STREAM : LIST_IDLE;
      end else begin
         if (w_accept) begin
            r_wcount <= r_wcount + c_CNT_W'(1);
         end
         if (w_drop) begin
            r_wovf <= 1'b1;
         end
         if (w_handshake) begin
            if (out_last) begin
               r_state <= LIST_IDLE;
            end else begin
               r_rptr <= r_rptr + c_PTR_W'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire
